// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RAW hazard scoreboard.
package hazard_pkg;

   // Widest destination field carried in a slot; supports up to 256 registers.
   localparam int unsigned DST_W     = 8;
   localparam int unsigned CNT_W_DEF = 16;

   typedef struct packed {
      logic             vld;
      logic [DST_W-1:0] dst;
      logic             ld;
   } slot_t;

   function automatic int unsigned reg_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hazard_slot_cmp.sv
// Compares one in-flight write slot against the ID stage source registers.
module hazard_slot_cmp
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W    = 3,
   parameter int unsigned FWD_EN   = 0,
   parameter int unsigned SLOT_IDX = 0
) (
   input  slot_t            slot,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             rs_used,
   input  logic             rt_used,
   output logic             hit_c
);

   logic qual_c;
   logic rs_hit_c;
   logic rt_hit_c;

   // With forwarding only a load still in EX cannot be bypassed.
   assign qual_c   = (FWD_EN == 0) | ((SLOT_IDX == 0) & slot.ld);
   assign rs_hit_c = rs_used & (slot.dst == DST_W'(rs));
   assign rt_hit_c = rt_used & (slot.dst == DST_W'(rt));
   assign hit_c    = slot.vld & qual_c & (rs_hit_c | rt_hit_c);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit: shift scoreboard of in-flight writes, decode stall,
// pending-register bitmap and saturating stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned FWD_EN   = 0,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   localparam int unsigned REG_W   = reg_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid_i,
   input  logic [REG_W-1:0]    rs_i,
   input  logic [REG_W-1:0]    rt_i,
   input  logic                rs_used_i,
   input  logic                rt_used_i,
   input  logic                wr_en_i,
   input  logic [REG_W-1:0]    wr_reg_i,
   input  logic                is_load_i,
   input  logic                mem_stall_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic [NUM_REGS-1:0] pend_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   slot_t             slots [DEPTH];
   slot_t             head_c;
   logic [DEPTH-1:0]  hit_c;
   logic              issue_c;
   logic [NUM_REGS-1:0] pend_c;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      hazard_slot_cmp #(
         .REG_W    (REG_W),
         .FWD_EN   (FWD_EN),
         .SLOT_IDX (g)
      ) u_cmp (
         .slot    (slots[g]),
         .rs      (rs_i),
         .rt      (rt_i),
         .rs_used (rs_used_i),
         .rt_used (rt_used_i),
         .hit_c   (hit_c[g])
      );
   end

   // Flush overrides any conflict.
   assign stall_o = id_valid_i & ~flush_i & (|hit_c);
   assign issue_c = id_valid_i & ~flush_i & ~stall_o & ~mem_stall_i;

   // Entry pushed into EX: the issued writer, otherwise a bubble.
   always_comb begin
      head_c = '0;
      if (issue_c && wr_en_i) begin
         head_c.vld = 1'b1;
         head_c.dst = DST_W'(wr_reg_i);
         head_c.ld  = is_load_i;
      end
   end

   // Scoreboard advances one stage per unfrozen cycle; the oldest slot retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
      end else if (!mem_stall_i) begin
         for (int k = 1; k < DEPTH; k++) slots[k] <= slots[k-1];
         slots[0] <= head_c;
      end
   end

   always_comb begin
      pend_c = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (slots[s].vld && (slots[s].dst == DST_W'(r))) pend_c[r] = 1'b1;
         end
      end
   end

   assign pend_o = pend_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
      end else if (stall_o && !mem_stall_i && !(&stall_cnt_o)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: interlock build (CNT_W=4) and load-use build
// side by side, checked against an in-flight-write list model.
module tb_hazard_scoreboard;

   localparam int unsigned NR = 8;
   localparam int unsigned RW = 3;
   localparam int unsigned D  = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, rs_used, rt_used, wr_en, is_load, mem_stall, flush;
   logic [RW-1:0] rs, rt, wr_reg;
   logic stall0, stall1;
   logic [NR-1:0] pend0, pend1;
   logic [3:0]  cnt0;
   logic [15:0] cnt1;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(NR), .DEPTH(D), .FWD_EN(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .rs_i(rs), .rt_i(rt),
      .rs_used_i(rs_used), .rt_used_i(rt_used), .wr_en_i(wr_en), .wr_reg_i(wr_reg),
      .is_load_i(is_load), .mem_stall_i(mem_stall), .flush_i(flush),
      .stall_o(stall0), .pend_o(pend0), .stall_cnt_o(cnt0));

   hazard_scoreboard #(.NUM_REGS(NR), .DEPTH(D), .FWD_EN(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .rs_i(rs), .rt_i(rt),
      .rs_used_i(rs_used), .rt_used_i(rt_used), .wr_en_i(wr_en), .wr_reg_i(wr_reg),
      .is_load_i(is_load), .mem_stall_i(mem_stall), .flush_i(flush),
      .stall_o(stall1), .pend_o(pend1), .stall_cnt_o(cnt1));

   // Model: list of writes in flight with the number of pipeline advances since issue.
   typedef struct {
      int unsigned dst;
      bit          ld;
      int unsigned age;
   } wr_t;

   wr_t         mq [2][$];
   int unsigned mcnt [2];
   int unsigned cmax [2] = '{15, 65535};
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model m=1 is the forwarding build: only a load issued last cycle blocks.
   function automatic bit m_hit(input int m, input int unsigned r);
      foreach (mq[m][i])
         if (mq[m][i].dst == r && (m == 0 || (mq[m][i].age == 0 && mq[m][i].ld))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stall(input int m);
      return id_valid && !flush &&
             ((rs_used && m_hit(m, int'(rs))) || (rt_used && m_hit(m, int'(rt))));
   endfunction

   function automatic logic [NR-1:0] m_pend(input int m);
      logic [NR-1:0] p = '0;
      foreach (mq[m][i]) p[mq[m][i].dst] = 1'b1;
      return p;
   endfunction

   task automatic m_adv(input int m, input bit st);
      wr_t nq[$];
      if (mem_stall) return;
      foreach (mq[m][i])
         if (mq[m][i].age + 1 < D) nq.push_back('{mq[m][i].dst, mq[m][i].ld, mq[m][i].age + 1});
      if (id_valid && !flush && !st && wr_en) nq.push_front('{int'(wr_reg), is_load, 0});
      mq[m] = nq;
      if (st) mcnt[m] = (mcnt[m] >= cmax[m]) ? cmax[m] : mcnt[m] + 1;
   endtask

   task automatic m_clear();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         mcnt[m] = 0;
      end
   endtask

   task automatic drv(input bit v, input int s, input int t, input bit su, input bit tu,
                      input bit we, input int wr, input bit ld, input bit ms, input bit fl);
      id_valid = v;  rs = RW'(s);  rt = RW'(t);  rs_used = su;  rt_used = tu;
      wr_en = we;  wr_reg = RW'(wr);  is_load = ld;  mem_stall = ms;  flush = fl;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic cycle(input string tag);
      bit s0, s1;
      @(negedge clk);
      s0 = m_stall(0);
      s1 = m_stall(1);
      chk({tag, "_stall_f0"}, 32'(stall0), 32'(s0));
      chk({tag, "_stall_f1"}, 32'(stall1), 32'(s1));
      chk({tag, "_pend_f0"}, 32'(pend0), 32'(m_pend(0)));
      chk({tag, "_pend_f1"}, 32'(pend1), 32'(m_pend(1)));
      chk({tag, "_cnt_f0"}, 32'(cnt0), mcnt[0]);
      chk({tag, "_cnt_f1"}, 32'(cnt1), mcnt[1]);
      @(posedge clk);
      m_adv(0, s0);
      m_adv(1, s1);
      #1;
   endtask

   // Reset asserted between edges: outputs must clear without waiting for a clock.
   task automatic reset_mid(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_rst_stall_f0"}, 32'(stall0), 32'd0);
      chk({tag, "_rst_stall_f1"}, 32'(stall1), 32'd0);
      chk({tag, "_rst_pend_f0"}, 32'(pend0), 32'd0);
      chk({tag, "_rst_pend_f1"}, 32'(pend1), 32'd0);
      chk({tag, "_rst_cnt_f0"}, 32'(cnt0), 32'd0);
      chk({tag, "_rst_cnt_f1"}, 32'(cnt1), 32'd0);
      m_clear();
      @(posedge clk);
      idle();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      m_clear();
      #12;
      chk("reset_stall_f0", 32'(stall0), 32'd0);
      chk("reset_pend_f0", 32'(pend0), 32'd0);
      chk("reset_cnt_f0", 32'(cnt0), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU producer r3 then consumer of r3: two interlock cycles, none with forwarding.
      drv(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);  cycle("t1_prod");
      drv(1, 3, 0, 1, 0, 1, 5, 0, 0, 0);  cycle("t1_c0");  cycle("t1_c1");  cycle("t1_c2");
      chk("t1_total_cnt_f0", 32'(cnt0), 32'd2);
      chk("t1_total_cnt_f1", 32'(cnt1), 32'd0);
      idle();  cycle("t1_i0");  cycle("t1_i1");  cycle("t1_i2");

      // Load r2 followed by a consumer reading it through rt.
      drv(1, 0, 0, 0, 0, 1, 2, 1, 0, 0);  cycle("t2_ld");
      drv(1, 0, 2, 0, 1, 1, 6, 0, 0, 0);  cycle("t2_c0");
      chk("t2_loaduse_cnt_f1", 32'(cnt1), 32'd1);
      cycle("t2_c1");  cycle("t2_c2");
      idle();  cycle("t2_i0");  cycle("t2_i1");  cycle("t2_i2");

      // Unused source fields never stall, even when they name a pending register.
      drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);  cycle("t3_prod");
      drv(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);  cycle("t3_rtoff");
      drv(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);  cycle("t3_nop");
      idle();  cycle("t3_i0");  cycle("t3_i1");

      // Memory freeze holds the scoreboard and the counter while a conflict waits.
      drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);  cycle("t4_prod");
      drv(1, 4, 0, 1, 0, 0, 0, 0, 1, 0);  cycle("t4_ms0");  cycle("t4_ms1");  cycle("t4_ms2");
      chk("t4_pend4_f0", 32'(pend0[4]), 32'd1);
      idle();  cycle("t4_i0");  cycle("t4_i1");  cycle("t4_i2");

      // Flush of a conflicting instruction: no stall, no entry for its destination.
      drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);  cycle("t5_prod");
      drv(1, 6, 6, 1, 1, 1, 7, 0, 0, 1);  cycle("t5_fl");
      idle();  cycle("t5_i0");
      chk("t5_no_r7_f0", 32'(pend0[7]), 32'd0);
      cycle("t5_i1");  cycle("t5_i2");

      // Back-to-back dependent chain on r1 to saturate the 4-bit counter, then reset mid-stall.
      drv(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 33; i++) cycle("t6_chain");
      chk("t6_sat_cnt_f0", 32'(cnt0), 32'd15);
      cycle("t6_sat_hold");
      reset_mid("t6");

      // Random traffic with periodic asynchronous resets.
      for (int n = 0; n < 450; n++) begin
         drv($urandom_range(0, 9) > 1, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 11) == 0);
         cycle("rnd");
         if (n % 150 == 149) reset_mid("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
